mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide engine that consumes the decoder's `mult_en_d`/`div_en_d`/`unsigned_instr_d` controls in the execute stage and produces the 64-bit HI/LO result for MULT, MULTU, DIV and DIVU. It is the responder to the decoder's HI/LO control interface. It holds `busy` while computing so hazard logic can stall dependent MFHI/MFLO and new multiply/divide issues. It pulses `done` when the HI/LO register file may capture `hi_result`/`lo_result`.

---
 rtl/md_pkg.sv | 21 ++
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/md_sign_fix.sv | 11 +
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the iterative multiply/divide unit.
package md_pkg;

  // Engine sequencing states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_SIGN = 2'b10
  } md_state_e;

  // Operation codes; these match the decoder's hi_src/lo_src encoding.
  typedef enum logic [1:0] {
    NO_MULT_DIV = 2'b00,
    MULT        = 2'b01,
    DIV         = 2'b10
  } md_op_e;

  // One iteration per operand bit.
  localparam int MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: decoder <-> multiply/divide unit HI/LO control bundle.
// master = decoder/issue side, slave = mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             mult_en;
  logic             div_en;
  logic             unsigned_op;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_result;
  logic [WIDTH-1:0] lo_result;

  modport master (
    output start, mult_en, div_en, unsigned_op, flush, src_a, src_b,
    input  busy, done, hi_result, lo_result
  );

  modport slave (
    input  start, mult_en, div_en, unsigned_op, flush, src_a, src_b,
    output busy, done, hi_result, lo_result
  );
endinterface

// File: rtl/md_sign_fix.sv
// md_sign_fix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to apply the final sign.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? (-i_val) : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine producing HI/LO.
// Radix-2 shift-add multiply, restoring divide, one bit per CALC cycle,
// followed by a single sign-correction cycle.
// Optional: define MD_FAST_MULT_EN for a single-cycle '*' multiply path
// (divides stay iterative).
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(MD_ITER);

  md_state_e        r_state, w_next;
  md_op_e           r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_sa, r_sb, r_dz;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_hi_res, r_lo_res;
  logic             r_done;

  logic             w_accept, w_iter_accept, w_fast;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  // Accept only from IDLE; flush beats start.
  assign w_accept = (r_state == MD_IDLE) && bus.start &&
                    (bus.mult_en || bus.div_en) && !bus.flush;

`ifdef MD_FAST_MULT_EN
  logic signed [2*WIDTH-1:0] w_sprod;
  logic        [2*WIDTH-1:0] w_uprod, w_fprod;
  // Kept as separate wires so the signed product is not forced unsigned by a mux.
  assign w_sprod = $signed(bus.src_a) * $signed(bus.src_b);
  assign w_uprod = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};
  assign w_fprod = bus.unsigned_op ? w_uprod : w_sprod;
  assign w_fast        = w_accept && !bus.div_en;
  assign w_iter_accept = w_accept &&  bus.div_en;
`else
  assign w_fast        = 1'b0;
  assign w_iter_accept = w_accept;
`endif

  // Operand signs; unsigned ops are treated as non-negative.
  assign w_sa = !bus.unsigned_op && bus.src_a[WIDTH-1];
  assign w_sb = !bus.unsigned_op && bus.src_b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) u_fix_a (.i_val(bus.src_a), .i_neg(w_sa), .o_val(w_mag_a));
  md_sign_fix #(.W(WIDTH)) u_fix_b (.i_val(bus.src_b), .i_neg(w_sb), .o_val(w_mag_b));

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (r_lo[0]) is set, then shift the whole 2W pair right.
  logic [WIDTH:0]   w_msum;
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

  // Divide step: 33-bit partial remainder = remainder shifted left with the
  // next dividend bit; subtract divisor when it fits.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // Final sign correction.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;
  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val({r_hi, r_lo}), .i_neg(r_sa ^ r_sb), .o_val(w_prod));
  md_sign_fix #(.W(WIDTH))   u_fix_quo  (.i_val(r_lo), .i_neg(r_sa ^ r_sb), .o_val(w_quo));
  md_sign_fix #(.W(WIDTH))   u_fix_rem  (.i_val(r_hi), .i_neg(r_sa),        .o_val(w_rem));

  // Divide by zero: restoring division leaves |a| as remainder, which the
  // remainder sign fix turns back into src_a; quotient is forced to all ones.
  assign w_res_hi = (r_op == DIV) ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = (r_op == DIV) ? (r_dz ? '1 : w_quo) : w_prod[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: if (w_iter_accept) w_next = MD_CALC;
        MD_CALC: if (r_cnt == '0)   w_next = MD_SIGN;
        MD_SIGN: w_next = MD_IDLE;
        default: w_next = MD_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, and result/done registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= NO_MULT_DIV;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_res <= '0;
      r_lo_res <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_iter_accept) begin
        r_op  <= bus.div_en ? DIV : MULT;
        r_sa  <= w_sa;
        r_sb  <= w_sb;
        r_dz  <= bus.div_en && (bus.src_b == '0);
        r_a   <= w_mag_a;
        r_b   <= w_mag_b;
        r_hi  <= '0;
        r_lo  <= bus.div_en ? w_mag_a : w_mag_b;
        r_cnt <= CW'(MD_ITER - 1);
      end else if (r_state == MD_CALC && !bus.flush) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (r_op == DIV) begin
          r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_ge};
        end else begin
          r_hi <= w_msum[WIDTH:1];
          r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
        end
      end else if (r_state == MD_SIGN && !bus.flush) begin
        r_hi_res <= w_res_hi;
        r_lo_res <= w_res_lo;
        r_done   <= 1'b1;
      end
`ifdef MD_FAST_MULT_EN
      else if (w_fast) begin
        r_hi_res <= w_fprod[2*WIDTH-1:WIDTH];
        r_lo_res <= w_fprod[WIDTH-1:0];
        r_done   <= 1'b1;
      end
`endif
    end
  end

  assign bus.busy      = (r_state != MD_IDLE);
  assign bus.done      = r_done;
  assign bus.hi_result = r_hi_res;
  assign bus.lo_result = r_lo_res;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed, table-driven check of mult_div_unit.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        m;
    logic        d;
    logic        u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation starting in the current cycle (called #1 after an
  // edge) and wait for done; leaves the bench in the done cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit seen;
    int exp_lat;
`ifdef MD_FAST_MULT_EN
    exp_lat = v.d ? 34 : 1;
`else
    exp_lat = 34;
`endif
    bus.mult_en = v.m; bus.div_en = v.d; bus.unsigned_op = v.u;
    bus.src_a = v.a; bus.src_b = v.b; bus.start = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bus.start = 1'b0;
      if (lat == 1) chk($sformatf("vec%0d busy_c1", idx), 64'(bus.busy), 64'(exp_lat != 1));
      if (bus.done) seen = 1;
    end
    chk($sformatf("vec%0d done_seen", idx), 64'(seen), 64'd1);
    chk($sformatf("vec%0d latency", idx), 64'(lat), 64'(exp_lat));
    chk($sformatf("vec%0d busy_done", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("vec%0d hi", idx), 64'(bus.hi_result), 64'(v.hi));
    chk($sformatf("vec%0d lo", idx), 64'(bus.lo_result), 64'(v.lo));
  endtask

  vec_t vecs[12];

  initial begin
    int ndone;
    logic [31:0] prev_hi, prev_lo;
    vec_t v;

    //            m     d     u     a              b              hi             lo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14};

    bus.start = 0; bus.mult_en = 0; bus.div_en = 0; bus.unsigned_op = 0;
    bus.flush = 0; bus.src_a = '0; bus.src_b = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst hi",   64'(bus.hi_result), 64'd0);
    chk("rst lo",   64'(bus.lo_result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table; consecutive vectors issue in the previous done cycle.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Flush in cycle 10 of a DIV: no done, results held.
    prev_hi = bus.hi_result; prev_lo = bus.lo_result;
    bus.mult_en = 0; bus.div_en = 1; bus.unsigned_op = 1;
    bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.start = 1;
    ndone = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      bus.start = 0;
      if (bus.done) ndone++;
      if (c == 10) bus.flush = 1;
      if (c == 11) begin
        bus.flush = 0;
        chk("flush busy_next", 64'(bus.busy), 64'd0);
      end
    end
    chk("flush no_done", 64'(ndone), 64'd0);
    chk("flush hi_hold", 64'(bus.hi_result), 64'(prev_hi));
    chk("flush lo_hold", 64'(bus.lo_result), 64'(prev_lo));

    // Start held through busy: ignored until the done cycle, then accepted.
    bus.div_en = 1; bus.mult_en = 0; bus.unsigned_op = 1;
    bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1;
    @(posedge clk); #1;
    bus.src_a = 32'd50; bus.src_b = 32'd5;
    ndone = 0;
    for (int c = 2; c <= 80 && ndone < 2; c++) begin
      @(posedge clk); #1;
      if (c == 34) begin
        chk("hold done_c34", 64'(bus.done), 64'd1);
        chk("hold hi1", 64'(bus.hi_result), 64'd2);
        chk("hold lo1", 64'(bus.lo_result), 64'd14);
      end
      if (c == 35) begin
        bus.start = 0;
        chk("b2b busy_c35", 64'(bus.busy), 64'd1);
      end
      if (bus.done) begin
        ndone++;
        if (ndone == 2) begin
          chk("b2b latency", 64'(c), 64'd68);
          chk("b2b hi2", 64'(bus.hi_result), 64'd0);
          chk("b2b lo2", 64'(bus.lo_result), 64'd10);
        end
      end
    end
    chk("b2b done_count", 64'(ndone), 64'd2);
    bus.start = 0;

    // Asynchronous reset mid-divide.
    @(posedge clk); #1;
    bus.div_en = 1; bus.unsigned_op = 0; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    bus.start = 1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      bus.start = 0;
    end
    chk("arst busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(bus.busy), 64'd0);
    chk("arst done", 64'(bus.done), 64'd0);
    chk("arst hi",   64'(bus.hi_result), 64'd0);
    chk("arst lo",   64'(bus.lo_result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = vecs[2];
    run_vec(100, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
